seg7_scan_counter: RTL and testbench

Parametrised N-digit BCD up/down counter with a multiplexed 7-segment driver, for the Tang Nano 9K display boards. The whole block runs on one clock with tick enables and has no derived clocks. It adds load and clear, up/down counting, wrap flagging, leading-zero blanking, per-digit decimal points, PWM brightness and output polarity selection. It sits between board pins and user logic as the standard display front end.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_counter_bcd_digit.sv | 33 +++
 rtl/seg7_scan_counter.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_counter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, the 7-segment font and small helpers for the scanned BCD display.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  // Segment patterns in g..a order; codes 10-15 are blank.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic bcd_t clamp_bcd(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seg7_scan_counter_bcd_digit.sv
// One decade of the ripple BCD counter; carries chain combinationally between digits.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  bcd_t loadValue,
  input  logic step,
  input  logic down,
  input  logic carryIn,
  output bcd_t digit,
  output logic carryOut
);

  assign carryOut = carryIn && (down ? (digit == 4'd0) : (digit == 4'd9));

  // Digit register: reset > clear > load (clamped to 9) > rippled count step.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_bcd(loadValue);
    end else if (step && carryIn) begin
      if (down) digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      else      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down counter with a multiplexed, PWM-dimmed 7-segment driver.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int CLK_FREQUENCY = 27000000,
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_HZ       = 1000,
  parameter int COUNT_HZ      = 1,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 0
)
(
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    countEnable,
  input  logic                    countDown,
  input  logic                    clearIn,
  input  logic                    loadIn,
  input  logic [4*NUM_DIGITS-1:0] loadValue,
  input  logic [NUM_DIGITS-1:0]   dpMask,
  input  logic [3:0]              brightness,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   digitEnable,
  output logic [7:0]              segmentEnable
);

  localparam int COUNT_DIV = (CLK_FREQUENCY / COUNT_HZ < 1) ? 1 : CLK_FREQUENCY / COUNT_HZ;
  localparam int SCAN_DIV  = (CLK_FREQUENCY / SCAN_HZ < 1) ? 1 : CLK_FREQUENCY / SCAN_HZ;
  localparam int COUNT_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic INVERT  = (ACTIVE_LOW != 0);

  logic [COUNT_W-1:0]    count_pre;
  logic [SCAN_W-1:0]     scan_pre;
  logic                  count_tick;
  logic                  scan_tick;
  logic                  count_step;
  logic [NUM_DIGITS:0]   carry;
  bcd_t                  digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] scan_sel;
  logic [NUM_DIGITS-1:0] scan_next;
  logic                  scan_started;
  logic [3:0]            pwm_cnt;
  bcd_t                  sel_digit;
  logic                  sel_blank;
  logic                  sel_dp;
  logic [7:0]            seg_logic;
  logic [NUM_DIGITS-1:0] de_logic;

  assign count_tick = (count_pre == COUNT_W'(COUNT_DIV - 1));
  assign scan_tick  = (scan_pre == SCAN_W'(SCAN_DIV - 1));
  assign count_step = count_tick && countEnable;

  // Tick prescalers for the count rate and the digit slot rate.
  always_ff @(posedge clkIn) begin
    if (resetIn || count_tick) count_pre <= '0;
    else                       count_pre <= count_pre + COUNT_W'(1);
    if (resetIn || scan_tick)  scan_pre  <= '0;
    else                       scan_pre  <= scan_pre + SCAN_W'(1);
  end

  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clkIn),
      .rst      (resetIn),
      .clear    (clearIn),
      .load     (loadIn),
      .loadValue(loadValue[4*k +: 4]),
      .step     (count_step),
      .down     (countDown),
      .carryIn  (carry[k]),
      .digit    (digits[k]),
      .carryOut (carry[k+1])
    );
    assign value[4*k +: 4] = digits[k];
  end

  // Wrap pulses with the step that carries out of the top digit; clear and load suppress it.
  always_ff @(posedge clkIn) begin
    if (resetIn || clearIn || loadIn) wrap <= 1'b0;
    else                              wrap <= count_step && carry[NUM_DIGITS];
  end

  // Leading-zero blanking: digit k>0 goes dark when it and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (digits[k] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && all_zero;
    end
  end

  assign scan_next = scan_tick ? ((scan_sel << 1) | NUM_DIGITS'(scan_sel[NUM_DIGITS-1])) : scan_sel;

  // Scan slot register; starts on the top digit so the first tick lands on digit 0.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      scan_sel     <= NUM_DIGITS'(1) << (NUM_DIGITS - 1);
      scan_started <= 1'b0;
    end else begin
      scan_sel     <= scan_next;
      scan_started <= scan_started || scan_tick;
    end
  end

  // Free-running brightness PWM phase.
  always_ff @(posedge clkIn) begin
    if (resetIn) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 4'd1;
  end

  // Pick the digit, blank flag and decimal point for the slot being entered.
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_next[k]) begin
        sel_digit = digits[k];
        sel_blank = blank[k];
        sel_dp    = dpMask[k];
      end
    end
  end

  assign seg_logic = {sel_dp, sel_blank ? 7'h00 : SEG_FONT[sel_digit]};
  assign de_logic  = ((scan_started || scan_tick) && (pwm_cnt <= brightness)) ? scan_next : '0;

  // Pin registers hold the board polarity; segments load per slot, digit enable is re-gated each cycle.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      segmentEnable <= {8{INVERT}};
      digitEnable   <= {NUM_DIGITS{INVERT}};
    end else begin
      if (scan_tick) segmentEnable <= seg_logic ^ {8{INVERT}};
      digitEnable <= de_logic ^ {NUM_DIGITS{INVERT}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed bench for seg7_scan_counter with a scoreboard of expected outputs.
module tb_seg7_scan_counter;
  import seg7_pkg::*;

  localparam int SEL_VALUE  = 0;
  localparam int SEL_WRAP   = 1;
  localparam int SEL_DE     = 2;
  localparam int SEL_SEG    = 3;
  localparam int SEL_DE_AL  = 4;
  localparam int SEL_SEG_AL = 5;
  localparam int SEL_VAL_AL = 6;
  localparam int SEL_WR_AL  = 7;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        countEnable = 1'b0;
  logic        countDown = 1'b0;
  logic        clearIn = 1'b0;
  logic        loadIn = 1'b0;
  logic [15:0] loadValue = '0;
  logic [3:0]  dpMask = '0;
  logic [3:0]  brightness = 4'hF;
  logic [15:0] value, valueAl;
  logic        wrap, wrapAl;
  logic [3:0]  digitEnable, digitEnableAl;
  logic [7:0]  segmentEnable, segmentEnableAl;

  always #5 clkIn = ~clkIn;

  seg7_scan_counter #(
    .CLK_FREQUENCY(1000), .NUM_DIGITS(4), .SCAN_HZ(100), .COUNT_HZ(100),
    .BLANK_LEADING(1), .ACTIVE_LOW(0)
  ) dut (
    .clkIn(clkIn), .resetIn(resetIn), .countEnable(countEnable), .countDown(countDown),
    .clearIn(clearIn), .loadIn(loadIn), .loadValue(loadValue), .dpMask(dpMask),
    .brightness(brightness), .value(value), .wrap(wrap), .digitEnable(digitEnable),
    .segmentEnable(segmentEnable)
  );

  seg7_scan_counter #(
    .CLK_FREQUENCY(1000), .NUM_DIGITS(4), .SCAN_HZ(100), .COUNT_HZ(100),
    .BLANK_LEADING(1), .ACTIVE_LOW(1)
  ) dutAl (
    .clkIn(clkIn), .resetIn(resetIn), .countEnable(countEnable), .countDown(countDown),
    .clearIn(clearIn), .loadIn(loadIn), .loadValue(loadValue), .dpMask(dpMask),
    .brightness(brightness), .value(valueAl), .wrap(wrapAl), .digitEnable(digitEnableAl),
    .segmentEnable(segmentEnableAl)
  );

  // Reference timing: both prescalers divide by 10, scan index starts at 3.
  int         m_pre = 0;
  logic [1:0] m_idx = 2'd3;
  logic       m_tick;
  assign m_tick = (m_pre == 9);

  always @(posedge clkIn) begin
    if (resetIn) begin
      m_pre <= 0;
      m_idx <= 2'd3;
    end else begin
      m_pre <= (m_pre == 9) ? 0 : m_pre + 1;
      if (m_pre == 9) m_idx <= m_idx + 2'd1;
    end
  end

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_VALUE:  return value;
      SEL_WRAP:   return 16'(wrap);
      SEL_DE:     return 16'(digitEnable);
      SEL_SEG:    return 16'(segmentEnable);
      SEL_DE_AL:  return 16'(digitEnableAl);
      SEL_SEG_AL: return 16'(segmentEnableAl);
      SEL_VAL_AL: return valueAl;
      default:    return 16'(wrapAl);
    endcase
  endfunction

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input int sel, input logic [15:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sbq.push_back(it);
  endtask

  task automatic applyStimulus();
    @(posedge clkIn);
    #1;
  endtask

  task automatic checkOutput();
    sb_item_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      compare(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic waitTick(input string tag);
    int n = 0;
    while (!m_tick && n < 40) begin
      applyStimulus();
      n++;
    end
    if (!m_tick) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed no tick expected tick within 40 cycles", tag);
    end
  endtask

  task automatic countActive(input string tag, input logic [3:0] br, input int exp);
    int cnt = 0;
    int cntAl = 0;
    brightness = br;
    applyStimulus();
    applyStimulus();
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (digitEnable != 4'h0) cnt++;
      if (digitEnableAl != 4'hF) cntAl++;
    end
    compare(tag, 16'(cnt), 16'(exp));
    compare({tag, "_al"}, 16'(cntAl), 16'(exp));
  endtask

  initial begin
    logic [7:0] exp_seg [4];
    logic [1:0] nxt;
    logic [3:0] de_e, de_ae;
    logic [7:0] seg_e, seg_ae;
    exp_seg = '{8'h5B, 8'hE6, 8'h00, 8'h00};

    $display("[TB] reset");
    repeat (3) applyStimulus();
    expectOut("rst_value", SEL_VALUE, 16'h0000);
    expectOut("rst_wrap", SEL_WRAP, 16'h0);
    expectOut("rst_de", SEL_DE, 16'h0);
    expectOut("rst_seg", SEL_SEG, 16'h00);
    expectOut("rst_de_al", SEL_DE_AL, 16'hF);
    expectOut("rst_seg_al", SEL_SEG_AL, 16'hFF);
    checkOutput();
    resetIn = 1'b0;

    $display("[TB] first scan slot");
    waitTick("first_tick");
    expectOut("first_de", SEL_DE, 16'h1);
    expectOut("first_seg", SEL_SEG, 16'h3F);
    expectOut("first_de_al", SEL_DE_AL, 16'hE);
    expectOut("first_seg_al", SEL_SEG_AL, 16'hC0);
    applyStimulus();
    checkOutput();

    $display("[TB] up wrap");
    loadIn = 1'b1;
    loadValue = 16'h9999;
    expectOut("load9999", SEL_VALUE, 16'h9999);
    expectOut("load9999_al", SEL_VAL_AL, 16'h9999);
    expectOut("load_nowrap", SEL_WRAP, 16'h0);
    applyStimulus();
    checkOutput();
    loadIn = 1'b0;
    countEnable = 1'b1;
    countDown = 1'b0;
    waitTick("up_tick");
    expectOut("up_prewrap", SEL_WRAP, 16'h0);
    checkOutput();
    expectOut("up_value", SEL_VALUE, 16'h0000);
    expectOut("up_wrap", SEL_WRAP, 16'h1);
    expectOut("up_wrap_al", SEL_WR_AL, 16'h1);
    applyStimulus();
    checkOutput();
    countEnable = 1'b0;
    expectOut("up_wrap_end", SEL_WRAP, 16'h0);
    expectOut("up_hold", SEL_VALUE, 16'h0000);
    applyStimulus();
    checkOutput();

    $display("[TB] down wrap");
    countDown = 1'b1;
    countEnable = 1'b1;
    waitTick("down_tick");
    expectOut("down_value", SEL_VALUE, 16'h9999);
    expectOut("down_wrap", SEL_WRAP, 16'h1);
    applyStimulus();
    checkOutput();
    countEnable = 1'b0;
    expectOut("down_wrap_end", SEL_WRAP, 16'h0);
    expectOut("down_hold", SEL_VALUE, 16'h9999);
    applyStimulus();
    checkOutput();

    $display("[TB] ripple");
    loadIn = 1'b1;
    loadValue = 16'h0199;
    expectOut("load0199", SEL_VALUE, 16'h0199);
    applyStimulus();
    checkOutput();
    loadIn = 1'b0;
    countDown = 1'b0;
    countEnable = 1'b1;
    waitTick("ripple_up_tick");
    expectOut("ripple_up", SEL_VALUE, 16'h0200);
    expectOut("ripple_up_nowrap", SEL_WRAP, 16'h0);
    applyStimulus();
    checkOutput();
    countDown = 1'b1;
    waitTick("ripple_dn_tick");
    expectOut("ripple_down", SEL_VALUE, 16'h0199);
    applyStimulus();
    checkOutput();
    countEnable = 1'b0;

    $display("[TB] clamp and clear");
    loadIn = 1'b1;
    loadValue = 16'h12AF;
    expectOut("load_clamp", SEL_VALUE, 16'h1299);
    applyStimulus();
    checkOutput();
    clearIn = 1'b1;
    loadValue = 16'h5555;
    expectOut("clear_over_load", SEL_VALUE, 16'h0000);
    expectOut("clear_nowrap", SEL_WRAP, 16'h0);
    applyStimulus();
    checkOutput();
    clearIn = 1'b0;

    $display("[TB] blanking and decimal point");
    loadValue = 16'h0042;
    dpMask = 4'b0010;
    expectOut("load0042", SEL_VALUE, 16'h0042);
    applyStimulus();
    checkOutput();
    loadIn = 1'b0;
    for (int s = 0; s < 4; s++) begin
      waitTick("blank_tick");
      nxt = m_idx + 2'd1;
      de_e = 4'b0001 << nxt;
      de_ae = ~de_e;
      seg_e = exp_seg[nxt];
      seg_ae = ~seg_e;
      expectOut("blank_de", SEL_DE, 16'(de_e));
      expectOut("blank_seg", SEL_SEG, 16'(seg_e));
      expectOut("blank_de_al", SEL_DE_AL, 16'(de_ae));
      expectOut("blank_seg_al", SEL_SEG_AL, 16'(seg_ae));
      applyStimulus();
      checkOutput();
      compare("blank_index", 16'(onehot_to_index(8'(digitEnable))), 16'(nxt));
    end

    $display("[TB] brightness");
    countActive("pwm_b3", 4'd3, 4);
    countActive("pwm_b15", 4'd15, 16);
    countActive("pwm_b0", 4'd0, 1);
    brightness = 4'hF;

    $display("[TB] reset mid-count");
    loadIn = 1'b1;
    loadValue = 16'h9999;
    expectOut("pre_rst_load", SEL_VALUE, 16'h9999);
    applyStimulus();
    checkOutput();
    loadIn = 1'b0;
    countDown = 1'b0;
    countEnable = 1'b1;
    waitTick("rst_mid_tick");
    resetIn = 1'b1;
    expectOut("mid_rst_value", SEL_VALUE, 16'h0000);
    expectOut("mid_rst_wrap", SEL_WRAP, 16'h0);
    expectOut("mid_rst_de", SEL_DE, 16'h0);
    expectOut("mid_rst_seg", SEL_SEG, 16'h00);
    expectOut("mid_rst_de_al", SEL_DE_AL, 16'hF);
    expectOut("mid_rst_seg_al", SEL_SEG_AL, 16'hFF);
    applyStimulus();
    checkOutput();
    resetIn = 1'b0;
    countEnable = 1'b0;
    expectOut("post_rst_wrap", SEL_WRAP, 16'h0);
    expectOut("post_rst_value", SEL_VALUE, 16'h0000);
    expectOut("post_rst_de", SEL_DE, 16'h0);
    applyStimulus();
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
